adc_scan_sched: RTL and testbench
=================================

// Module: adc_scan_sched
// PURPOSE
//  Scheduler for the adc_18s022 SPI driver. On a periodic tick it scans the enabled
//  ADC channels in ascending order. For each channel it runs 2**AVG_LOG2 conversions,
//  averages them and writes one result per channel. It is the sole owner of the
//  driver's En_convert/channel inputs; the application reads averaged samples only.
// PARAMETERS
//  SAMPLE_PERIOD  50000  Clk cycles between scan ticks (1 ms at 50 MHz); must be >= 2
//  AVG_LOG2       2      log2 of conversions averaged per channel (0..4)
//  TIMEOUT        2048   Clk cycles allowed from En_convert to Convert_done
// PORTS
//  Clk          in   1   system clock, 50 MHz
//  Rst          in   1   asynchronous reset, active-high
//  Scan_en      in   1   level; enables tick generation and scanning
//  Ch_mask      in   8   channel enable mask; sampled at scan start
//  Err_clr      in   1   pulse; clears Timeout_err and Overrun
//  En_convert   out  1   1-cycle pulse to driver, starts one conversion
//  Adc_channel  out  3   channel address to driver; stable from En_convert to Convert_done
//  Convert_done in   1   1-cycle pulse from driver, Adc_result valid this cycle
//  Adc_state    in   1   driver busy level
//  Adc_result   in   12  conversion data from driver
//  Res_valid    out  1   1-cycle pulse; Res_channel/Res_data valid
//  Res_channel  out  3   channel of the averaged result
//  Res_data     out  12  averaged result
//  Scan_done    out  1   1-cycle pulse after the last enabled channel of a scan
//  Busy         out  1   high from scan start until the cycle after Scan_done
//  Timeout_err  out  1   sticky; a conversion timed out
//  Overrun      out  1   sticky; a tick arrived while Busy
// BEHAVIOUR
//  - Reset: all outputs 0. FSM in IDLE. Tick counter and accumulator cleared.
//  - Tick: counter runs only while Scan_en=1 and pulses tick every SAMPLE_PERIOD cycles.
//    When Scan_en=0 the counter holds at 0.
//  - FSM states: IDLE -> PICK -> START -> WAIT_DONE -> ACCUM -> (START | WRITE) -> PICK ... -> DONE -> IDLE.
//  - IDLE: on tick with mask!=0, latch Ch_mask, set Busy, index=0, go to PICK.
//    A tick with mask==0 is ignored: no Busy, no Scan_done.
//  - PICK: find the lowest set bit of the latched mask at index >= current index.
//    If none remain, go to DONE.
//  - START: wait for Adc_state=0, then pulse En_convert with Adc_channel and load the
//    timeout counter. Go to WAIT_DONE the next cycle.
//  - WAIT_DONE: on Convert_done, acc += Adc_result and go to ACCUM.
//    If the timeout counter reaches TIMEOUT first: set Timeout_err, discard the channel's
//    accumulator, skip the channel (no Res_valid), go to PICK with index+1.
//  - ACCUM: if 2**AVG_LOG2 conversions are done, go to WRITE; else go to START.
//  - WRITE: Res_data = acc[11+AVG_LOG2:AVG_LOG2] (truncating), Res_valid=1 for 1 cycle.
//    Clear acc; index+1; go to PICK. Accumulator width is 12+AVG_LOG2 and never overflows.
//  - DONE: pulse Scan_done. Busy drops the next cycle. Return to IDLE.
//  - Latency, per channel: 2**AVG_LOG2 x (driver conversion time + 3 Clk) + 1.
//  - Tick while Busy: set Overrun and drop the tick (no queueing).
//  - Tick in the same cycle as Scan_done: treated as Busy (Overrun, dropped).
//  - Scan_en falls mid-scan: finish the outstanding conversion, emit no partial result,
//    then go to IDLE without Scan_done. Busy falls.
//  - Err_clr in the same cycle as a new error: the set wins.
//  - Rst mid-conversion: FSM returns to IDLE at once. The driver shares the reset.
//  - Convert_done outside WAIT_DONE is ignored.
// STRUCTURE
//  - adc_pkg: ADC_DW=12, CH_NUM=8, CH_W=3, and FSM state localparams.
//  - Sub-module adc_tick_gen: SAMPLE_PERIOD counter with enable; outputs a 1-cycle tick.
//  - Next-channel priority encoder is inline combinational logic.
// TESTING
//  - AVG_LOG2=2, mask=8'h05, ADC model returns 100,104,108,112 on ch0 -> Res_valid
//    ch0=106; then ch2; then Scan_done; 8 En_convert pulses total.
//  - mask=8'h00 with Scan_en=1 over 3 periods -> no En_convert, no Scan_done, Busy stays 0.
//  - Model withholds Convert_done on ch1, mask=8'h03 -> Timeout_err=1 after 2048 cycles;
//    only ch0 result is written; Scan_done still pulses.
//  - SAMPLE_PERIOD=100 with a slow model -> Overrun=1, no second scan starts mid-scan;
//    Err_clr clears it.
//  - Drop Scan_en during ch3's 2nd conversion -> that conversion completes, no Res_valid
//    for ch3, IDLE, no Scan_done.
//  - Assert Rst in WAIT_DONE -> all outputs 0 next cycle; a new tick restarts from the
//    lowest enabled channel.

Source files
------------

// File: rtl/adc_scan_sched_pkg.sv
// Shared widths and scheduler state encoding for the ADC scan scheduler.
package adc_scan_sched_pkg;

  localparam int ADC_DW = 12;
  localparam int CH_NUM = 8;
  localparam int CH_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_START,
    S_WAIT_DONE,
    S_ACCUM,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/adc_scan_sched_tick_gen.sv
// Free-running scan tick: one-cycle pulse every SAMPLE_PERIOD cycles while enabled.
module adc_scan_sched_tick_gen #(
  parameter int SAMPLE_PERIOD = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_scan_sched.sv
// Scans enabled ADC channels on each tick, averages 2**AVG_LOG2 conversions per
// channel and emits one result per channel; owns the SPI driver's start/channel inputs.
module adc_scan_sched
  import adc_scan_sched_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 50000,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT       = 2048
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scan_en_i,
  input  logic [CH_NUM-1:0] ch_mask_i,
  input  logic              err_clr_i,
  output logic              en_convert_o,
  output logic [CH_W-1:0]   adc_channel_o,
  input  logic              convert_done_i,
  input  logic              adc_state_i,
  input  logic [ADC_DW-1:0] adc_result_i,
  output logic              res_valid_o,
  output logic [CH_W-1:0]   res_channel_o,
  output logic [ADC_DW-1:0] res_data_o,
  output logic              scan_done_o,
  output logic              busy_o,
  output logic              timeout_err_o,
  output logic              overrun_o
);

  localparam int ACC_W   = ADC_DW + AVG_LOG2;
  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam int NCONV_W = AVG_LOG2 + 1;
  localparam logic [NCONV_W-1:0] NCONV    = NCONV_W'(1 << AVG_LOG2);
  localparam logic [TMO_W-1:0]   TMO_LOAD = TMO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CH_NUM-1:0]   mask_q, mask_d;
  logic [CH_W:0]       idx_q, idx_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NCONV_W-1:0]  nconv_q, nconv_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                tmo_err_q, tmo_err_d;
  logic                ovr_q, ovr_d;
  logic                tick, busy, tmo_set, pick_found;
  logic [CH_W-1:0]     pick_ch;

  adc_scan_sched_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (scan_en_i),
    .tick_o (tick)
  );

  assign busy = (state_q != S_IDLE);

  // Lowest enabled channel at or above the scan index; walk downwards so the lowest wins.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (mask_q[i] && (idx_q <= (CH_W + 1)'(i))) begin
        pick_found = 1'b1;
        pick_ch    = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    idx_d        = idx_q;
    ch_d         = ch_q;
    nconv_d      = nconv_q;
    acc_d        = acc_q;
    tmo_d        = tmo_q;
    tmo_set      = 1'b0;
    en_convert_o = 1'b0;
    res_valid_o  = 1'b0;
    res_data_o   = '0;
    scan_done_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick && (ch_mask_i != '0)) begin
          mask_d  = ch_mask_i;
          idx_d   = '0;
          acc_d   = '0;
          nconv_d = '0;
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        if (!scan_en_i)      state_d = S_IDLE;
        else if (pick_found) begin
          ch_d    = pick_ch;
          state_d = S_START;
        end else             state_d = S_DONE;
      end
      S_START: begin
        if (!scan_en_i) state_d = S_IDLE;
        else if (!adc_state_i) begin
          en_convert_o = 1'b1;
          tmo_d        = TMO_LOAD;
          state_d      = S_WAIT_DONE;
        end
      end
      // A conversion in flight always runs to completion, even when scanning is withdrawn.
      S_WAIT_DONE: begin
        if (convert_done_i) begin
          acc_d   = acc_q + ACC_W'(adc_result_i);
          nconv_d = nconv_q + NCONV_W'(1);
          state_d = scan_en_i ? S_ACCUM : S_IDLE;
        end else if (tmo_q == '0) begin
          tmo_set = 1'b1;
          acc_d   = '0;
          nconv_d = '0;
          idx_d   = {1'b0, ch_q} + (CH_W + 1)'(1);
          state_d = scan_en_i ? S_PICK : S_IDLE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_ACCUM: begin
        if (!scan_en_i)          state_d = S_IDLE;
        else if (nconv_q == NCONV) state_d = S_WRITE;
        else                     state_d = S_START;
      end
      S_WRITE: begin
        res_valid_o = 1'b1;
        res_data_o  = acc_q[ACC_W-1:AVG_LOG2];
        acc_d       = '0;
        nconv_d     = '0;
        idx_d       = {1'b0, ch_q} + (CH_W + 1)'(1);
        state_d     = S_PICK;
      end
      S_DONE: begin
        scan_done_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tmo_err_d = tmo_set | (tmo_err_q & ~err_clr_i);
  assign ovr_d     = (tick & busy) | (ovr_q & ~err_clr_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      idx_q     <= '0;
      ch_q      <= '0;
      nconv_q   <= '0;
      acc_q     <= '0;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      ch_q      <= ch_d;
      nconv_q   <= nconv_d;
      acc_q     <= acc_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign adc_channel_o = ch_q;
  assign res_channel_o = ch_q;
  assign busy_o        = busy;
  assign timeout_err_o = tmo_err_q;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_adc_scan_sched.sv
// Bench for adc_scan_sched: behavioural SPI-driver model plus per-scan expected results.
module tb_adc_scan_sched;

  localparam int SP = 400;
  localparam int AVG = 2;
  localparam int NC = 1 << AVG;
  localparam int TO = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_en = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic        err_clr = 1'b0;
  logic        convert_done = 1'b0;
  logic        adc_state = 1'b0;
  logic [11:0] adc_result = '0;
  logic        en_convert_o, res_valid_o, scan_done_o, busy_o, timeout_err_o, overrun_o;
  logic [2:0]  adc_channel_o, res_channel_o;
  logic [11:0] res_data_o;

  int tests_run = 0;
  int tests_failed = 0;

  int  conv_time = 4;
  bit  fixed_mode = 1'b0;
  bit  withhold [8];
  int  en_log [$];
  int  vals [8][$];
  int  rv_ch [$];
  int  rv_data [$];
  int  sd_cnt = 0;
  int  busy_cyc = 0;
  int  cyc = 0;
  int  t_ch1 = 0;
  int  t_terr = 0;
  bit  terr_prev = 1'b0;

  adc_scan_sched #(.SAMPLE_PERIOD(SP), .AVG_LOG2(AVG), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .scan_en_i(scan_en), .ch_mask_i(ch_mask), .err_clr_i(err_clr),
    .en_convert_o(en_convert_o), .adc_channel_o(adc_channel_o), .convert_done_i(convert_done),
    .adc_state_i(adc_state), .adc_result_i(adc_result), .res_valid_o(res_valid_o),
    .res_channel_o(res_channel_o), .res_data_o(res_data_o), .scan_done_o(scan_done_o),
    .busy_o(busy_o), .timeout_err_o(timeout_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Driver model: busy for conv_time cycles after each start, then returns a sample.
  initial begin : adc_model
    int ph, left, ch, v;
    ph = 0; left = 0; ch = 0; v = 0;
    forever begin
      @(negedge clk);
      convert_done = 1'b0;
      if (rst) begin
        ph = 0;
        adc_state = 1'b0;
      end else if (ph == 0) begin
        if (en_convert_o) begin
          ch = int'(adc_channel_o);
          en_log.push_back(ch);
          ph = 1;
        end
      end else if (ph == 1) begin
        adc_state = 1'b1;
        left = conv_time;
        ph = 2;
      end else begin
        left--;
        if (left == 0) begin
          adc_state = 1'b0;
          ph = 0;
          if (!withhold[ch]) begin
            v = fixed_mode ? 100 + 16 * ch + 4 * vals[ch].size() : int'($urandom_range(0, 4095));
            vals[ch].push_back(v);
            adc_result = 12'(v);
            convert_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (res_valid_o) begin
        rv_ch.push_back(int'(res_channel_o));
        rv_data.push_back(int'(res_data_o));
      end
      if (scan_done_o) sd_cnt++;
      if (busy_o) busy_cyc++;
      if (en_convert_o && adc_channel_o == 3'd1) t_ch1 = cyc;
      if (timeout_err_o && !terr_prev) t_terr = cyc;
      terr_prev = timeout_err_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    en_log.delete();
    for (int c = 0; c < 8; c++) vals[c].delete();
    rv_ch.delete();
    rv_data.delete();
  endtask

  task automatic run_scan(input string tag, input logic [7:0] mask, input int budget);
    int base;
    bit seen;
    base = sd_cnt;
    seen = 1'b0;
    ch_mask = mask;
    scan_en = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (scan_done_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_scan_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    scan_en = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_scan_done_once"}, sd_cnt - base, 32'd1);
    chk({tag, "_busy_after"}, 32'(busy_o), 32'd0);
  endtask

  // Expected scan outcome: ascending enabled channels, NC conversions each, truncated mean.
  task automatic check_scan(input string tag, input logic [7:0] mask);
    int exp_ch [$];
    int exp_avg [$];
    int exp_seq [$];
    int sum, bad;
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        if (withhold[c]) exp_seq.push_back(c);
        else begin
          for (int k = 0; k < NC; k++) exp_seq.push_back(c);
          sum = 0;
          for (int k = 0; k < vals[c].size(); k++) sum += vals[c][k];
          exp_ch.push_back(c);
          exp_avg.push_back(sum / NC);
        end
      end
    end
    chk({tag, "_n_results"}, rv_ch.size(), exp_ch.size());
    for (int i = 0; i < exp_ch.size() && i < rv_ch.size(); i++) begin
      chk({tag, "_res_ch"}, rv_ch[i], exp_ch[i]);
      chk({tag, "_res_data"}, rv_data[i], exp_avg[i]);
    end
    chk({tag, "_n_conversions"}, en_log.size(), exp_seq.size());
    bad = 0;
    for (int i = 0; i < exp_seq.size() && i < en_log.size(); i++)
      if (en_log[i] != exp_seq[i]) bad++;
    chk({tag, "_conv_order_errs"}, bad, 32'd0);
  endtask

  initial begin : main
    logic [7:0] m;
    int k, base_sd, base_busy, low;
    for (int c = 0; c < 8; c++) withhold[c] = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_en_convert", 32'(en_convert_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_res_valid", 32'(res_valid_o), 32'd0);
    chk("rst_scan_done", 32'(scan_done_o), 32'd0);
    chk("rst_adc_channel", 32'(adc_channel_o), 32'd0);
    chk("rst_res_data", 32'(res_data_o), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed ramp data on ch0 and ch2
    fixed_mode = 1'b1;
    conv_time = 4;
    clear_logs();
    run_scan("dir05", 8'h05, 3 * SP);
    check_scan("dir05", 8'h05);
    if (rv_data.size() == 2) begin
      chk("dir05_ch0_avg", rv_data[0], 32'd106);
      chk("dir05_ch2_avg", rv_data[1], 32'd138);
    end else chk("dir05_result_count", rv_data.size(), 32'd2);
    chk("dir05_total_conv", en_log.size(), 32'd8);

    // Random masks and data
    fixed_mode = 1'b0;
    for (int r = 0; r < 4; r++) begin
      m = 8'($urandom_range(1, 255));
      conv_time = int'($urandom_range(2, 5));
      clear_logs();
      run_scan("rand", m, 3 * SP);
      check_scan("rand", m);
      chk("rand_no_overrun", 32'(overrun_o), 32'd0);
    end

    // Empty mask: ticks are ignored
    clear_logs();
    base_sd = sd_cnt;
    base_busy = busy_cyc;
    ch_mask = 8'h00;
    scan_en = 1'b1;
    repeat (3 * SP + 10) @(negedge clk);
    scan_en = 1'b0;
    chk("mask0_conversions", en_log.size(), 32'd0);
    chk("mask0_scan_done", sd_cnt - base_sd, 32'd0);
    chk("mask0_busy_cycles", busy_cyc - base_busy, 32'd0);

    // Channel 1 never answers
    conv_time = 3;
    withhold[1] = 1'b1;
    clear_logs();
    run_scan("tmo", 8'h03, 4 * TO);
    check_scan("tmo", 8'h03);
    chk("tmo_err_set", 32'(timeout_err_o), 32'd1);
    chk("tmo_latency_ok", 32'((t_terr - t_ch1 >= TO) && (t_terr - t_ch1 <= TO + 2)), 32'd1);
    chk("tmo_overrun_set", 32'(overrun_o), 32'd1);
    withhold[1] = 1'b0;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("tmo_err_cleared", 32'(timeout_err_o), 32'd0);
    chk("tmo_overrun_cleared", 32'(overrun_o), 32'd0);

    // Slow driver: scan outlasts several tick periods
    conv_time = 40;
    clear_logs();
    run_scan("ovr", 8'hFF, 10 * SP);
    check_scan("ovr", 8'hFF);
    chk("ovr_set", 32'(overrun_o), 32'd1);
    chk("ovr_no_timeout", 32'(timeout_err_o), 32'd0);
    repeat (5) @(negedge clk);
    chk("ovr_sticky", 32'(overrun_o), 32'd1);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun_o), 32'd0);

    // Scanning withdrawn during ch3's second conversion
    conv_time = 4;
    clear_logs();
    base_sd = sd_cnt;
    ch_mask = 8'h09;
    scan_en = 1'b1;
    k = 0;
    for (int i = 0; i < 3 * SP && k < 2; i++) begin
      @(negedge clk);
      if (en_convert_o && adc_channel_o == 3'd3) k++;
    end
    chk("drop_ch3_second_start", k, 32'd2);
    @(negedge clk);
    scan_en = 1'b0;
    chk("drop_busy_while_finishing", 32'(busy_o), 32'd1);
    repeat (20) @(negedge clk);
    chk("drop_busy_fallen", 32'(busy_o), 32'd0);
    chk("drop_n_results", rv_ch.size(), 32'd1);
    if (rv_ch.size() > 0) chk("drop_result_ch", rv_ch[0], 32'd0);
    chk("drop_no_scan_done", sd_cnt - base_sd, 32'd0);
    chk("drop_total_conv", en_log.size(), 32'd6);

    // Reset while waiting on a conversion, then a clean restart
    m = 8'($urandom_range(1, 255)) | 8'h80;
    low = 0;
    for (int c = 7; c >= 0; c--) if (m[c]) low = c;
    clear_logs();
    ch_mask = m;
    scan_en = 1'b1;
    k = 0;
    for (int i = 0; i < 3 * SP && k == 0; i++) begin
      @(negedge clk);
      if (en_convert_o) k = 1;
    end
    chk("rstw_conv_started", k, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstw_busy", 32'(busy_o), 32'd0);
    chk("rstw_en_convert", 32'(en_convert_o), 32'd0);
    chk("rstw_adc_channel", 32'(adc_channel_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    run_scan("rstw", m, 3 * SP);
    check_scan("rstw", m);
    if (en_log.size() > 0) chk("rstw_first_channel", en_log[0], low);
    else chk("rstw_any_conversion", en_log.size(), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
